// File: rtl/serial_tx.sv
// Parallel-to-serial transmitter: one-cycle start marker, then `size` data bits,
// then GAP_CYCLES idle cycles. All outputs are registered from next-state values.
module serial_tx #(
  parameter int unsigned size       = 8,
  parameter int unsigned GAP_CYCLES = 1,
  parameter int unsigned MSB_FIRST  = 0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            load,
  input  logic [size-1:0] TxData_in,
  output logic            ready,
  output logic            valid,
  output logic            Data_out,
  output logic            tx_done
);

  localparam int unsigned CW = $clog2(size);
  localparam int unsigned GW = $clog2(GAP_CYCLES + 2);
  localparam logic [CW-1:0] LAST_BIT = CW'(size - 1);
  localparam logic [GW-1:0] LAST_GAP = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, START, SHIFT, GAP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [size-1:0] sh_q, sh_d;
  logic            ready_d, valid_d, dout_d, done_d;
  logic            head;
  logic [size-1:0] shifted;

  // Head of the shift register is the next bit on the wire.
  assign head    = (MSB_FIRST != 0) ? sh_q[size-1] : sh_q[0];
  assign shifted = (MSB_FIRST != 0) ? {sh_q[size-2:0], 1'b0} : {1'b0, sh_q[size-1:1]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    sh_d    = sh_q;
    dout_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          sh_d    = TxData_in;
          state_d = START;
          dout_d  = 1'b1;
        end
      end
      START: begin
        state_d = SHIFT;
        cnt_d   = '0;
        dout_d  = head;
        sh_d    = shifted;
      end
      SHIFT: begin
        if (cnt_q == LAST_BIT) begin
          cnt_d = '0;
          gap_d = '0;
          state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
        end else begin
          cnt_d  = cnt_q + CW'(1);
          dout_d = head;
          sh_d   = shifted;
        end
      end
      GAP: begin
        if (gap_q == LAST_GAP) state_d = IDLE;
        else                   gap_d = gap_q + GW'(1);
      end
      default: state_d = IDLE;
    endcase
    // Registered outputs decode the state being entered, so they line up with it.
    ready_d = (state_d == IDLE);
    valid_d = (state_d == START);
    done_d  = (state_d == SHIFT) && (cnt_d == LAST_BIT);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      gap_q    <= '0;
      sh_q     <= '0;
      ready    <= 1'b1;
      valid    <= 1'b0;
      Data_out <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gap_q    <= gap_d;
      sh_q     <= sh_d;
      ready    <= ready_d;
      valid    <= valid_d;
      Data_out <= dout_d;
      tx_done  <= done_d;
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: default instance (LSB first, one gap cycle) and an
// MSB-first instance with no gap; a bench-side receiver reassembles each frame.
module tb_serial_tx;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       load0 = 1'b0, load1 = 1'b0;
  logic [7:0] data0 = '0, data1 = '0;
  logic       ready0, valid0, dout0, done0;
  logic       ready1, valid1, dout1, done1;
  int         n_vec = 0;
  int         n_err = 0;

  always #50 clock = ~clock;

  serial_tx #(.size(8), .GAP_CYCLES(1), .MSB_FIRST(0)) dut (
    .clock(clock), .reset(reset), .load(load0), .TxData_in(data0),
    .ready(ready0), .valid(valid0), .Data_out(dout0), .tx_done(done0)
  );

  serial_tx #(.size(8), .GAP_CYCLES(0), .MSB_FIRST(1)) dut_msb (
    .clock(clock), .reset(reset), .load(load1), .TxData_in(data1),
    .ready(ready1), .valid(valid1), .Data_out(dout1), .tx_done(done1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // {ready, valid, Data_out, tx_done}
  function automatic logic [3:0] obs(input int w);
    return (w != 0) ? {ready1, valid1, dout1, done1} : {ready0, valid0, dout0, done0};
  endfunction

  task automatic frame(input int w, input logic [7:0] d, input int gap);
    logic [7:0] rx;
    logic       b;
    logic [3:0] o;
    rx = '0;
    if (w != 0) begin load1 = 1'b1; data1 = d; end
    else        begin load0 = 1'b1; data0 = d; end
    tick;
    load0 = 1'b0; load1 = 1'b0;
    data0 = ~d;   data1 = ~d;
    check($sformatf("start_%0h", d), obs(w), 4'b0110);
    for (int k = 0; k < 8; k++) begin
      tick;
      b = (w != 0) ? d[7-k] : d[k];
      o = obs(w);
      check($sformatf("bit%0d_%0h", k, d), o, {2'b00, b, (k == 7)});
      if (w != 0) rx[7-k] = o[1];
      else        rx[k]   = o[1];
    end
    check($sformatf("rxword_%0h", d), rx, d);
    for (int g = 0; g < gap; g++) begin
      tick;
      check($sformatf("gap_%0h", d), obs(w), 4'b0000);
    end
    tick;
    check($sformatf("idle_%0h", d), obs(w), 4'b1000);
  endtask

  initial begin
    int st[4];
    int nv;
    int wt;

    tick; tick;
    check("rst0", obs(0), 4'b1000);
    check("rst1", obs(1), 4'b1000);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      check("idle_after_rst", obs(0), 4'b1000);
    end

    frame(0, 8'hAA, 1);
    frame(1, 8'h81, 0);

    // load held high: starts every 2+8+1 = 11 cycles
    nv = 0;
    load0 = 1'b1; data0 = 8'h3C;
    for (int c = 1; c <= 30; c++) begin
      tick;
      if (valid0) begin
        if (nv < 4) st[nv] = c;
        nv++;
        check("valid_vs_ready", ready0, 1'b0);
      end
    end
    load0 = 1'b0;
    check("held_count", nv, 3);
    check("held_start0", st[0], 1);
    check("held_start1", st[1], 12);
    check("held_start2", st[2], 23);
    wt = 0;
    while (!ready0 && wt < 20) begin tick; wt++; end
    check("held_drain", ready0, 1'b1);
    tick;

    // reset in the 4th SHIFT cycle, with load also high on that edge
    load0 = 1'b1; data0 = 8'hFF;
    tick;
    load0 = 1'b0;
    for (int i = 0; i < 4; i++) tick;
    check("mid_shift", obs(0), 4'b0010);
    reset = 1'b1; load0 = 1'b1;
    tick;
    check("rst_mid", obs(0), 4'b1000);
    reset = 1'b0; load0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      check("post_rst_quiet", obs(0), 4'b1000);
    end
    frame(0, 8'h01, 1);

    frame(0, 8'h55, 1);
    frame(0, 8'hC3, 1);
    frame(1, 8'h3C, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
